// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: merges ALU and MFPU write-back requests into one VRF write port.
// Each source is buffered in a small FIFO. A two-state arbiter alternates winners on ties
// and holds its choice while the VRF bank applies backpressure.
// Optional feature: define VRF_WB_STALL_CNT_EN to enable a saturating backpressure
// counter on stall_cnt_o. When the macro is undefined, stall_cnt_o is tied to zero.
module vrf_wb_arbiter #(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 10,
    parameter int IdWidth   = 3,
    parameter int Depth     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alu_result_req_i,
    input  logic [IdWidth-1:0]     alu_result_id_i,
    input  logic [AddrWidth-1:0]   alu_result_addr_i,
    input  logic [DataWidth-1:0]   alu_result_wdata_i,
    input  logic [DataWidth/8-1:0] alu_result_be_i,
    output logic                   alu_result_gnt_o,
    input  logic                   mfpu_result_req_i,
    input  logic [IdWidth-1:0]     mfpu_result_id_i,
    input  logic [AddrWidth-1:0]   mfpu_result_addr_i,
    input  logic [DataWidth-1:0]   mfpu_result_wdata_i,
    input  logic [DataWidth/8-1:0] mfpu_result_be_i,
    output logic                   mfpu_result_gnt_o,
    output logic                   vrf_req_o,
    output logic [IdWidth-1:0]     vrf_id_o,
    output logic [AddrWidth-1:0]   vrf_addr_o,
    output logic [DataWidth-1:0]   vrf_wdata_o,
    output logic [DataWidth/8-1:0] vrf_be_o,
    input  logic                   vrf_gnt_i,
    output logic [15:0]            stall_cnt_o
);

    localparam int BeWidth  = DataWidth / 8;
    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = PtrWidth + 1;
    localparam int EntWidth = IdWidth + AddrWidth + DataWidth + BeWidth;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // Source index 0 is the ALU and source index 1 is the MFPU.
    logic [EntWidth-1:0] mem_q [2][Depth];
    logic [PtrWidth-1:0] rptr_q [2];
    logic [PtrWidth-1:0] wptr_q [2];
    logic [CntWidth-1:0] cnt_q [2];

    logic [EntWidth-1:0] ent_in [2];
    logic [1:0]          req_in;
    logic [1:0]          push;
    logic [1:0]          pop;
    logic [1:0]          not_empty;

    logic [0:0] state_q, state_d;
    logic       lock_src_q, lock_src_d;
    logic       last_q, last_d;
    logic       sel;
    logic       sel_vld;
    logic [EntWidth-1:0] head;

    assign ent_in[0] = {alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i};
    assign ent_in[1] = {mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i};
    assign req_in    = {mfpu_result_req_i, alu_result_req_i};

    // Acceptance uses only registered occupancy, so a full FIFO cannot take a push even when it pops.
    always_comb begin
        push      = '0;
        not_empty = '0;
        for (int s = 0; s < 2; s++) begin
            push[s]      = req_in[s] && (cnt_q[s] != CntWidth'(Depth)) && !rst_i;
            not_empty[s] = (cnt_q[s] != '0);
        end
    end

    assign alu_result_gnt_o  = push[0];
    assign mfpu_result_gnt_o = push[1];

    // Source selection: a locked source is held; otherwise a tie goes to the previous loser.
    always_comb begin
        sel     = 1'b0;
        sel_vld = 1'b0;
        if (state_q == LOCKED) begin
            sel     = lock_src_q;
            sel_vld = 1'b1;
        end else if (not_empty[0] && not_empty[1]) begin
            sel     = !last_q;
            sel_vld = 1'b1;
        end else if (not_empty[0]) begin
            sel     = 1'b0;
            sel_vld = 1'b1;
        end else if (not_empty[1]) begin
            sel     = 1'b1;
            sel_vld = 1'b1;
        end
    end

    assign vrf_req_o = sel_vld && !rst_i;
    assign head      = mem_q[sel][rptr_q[sel]];
    assign pop[0]    = vrf_req_o && vrf_gnt_i && (sel == 1'b0);
    assign pop[1]    = vrf_req_o && vrf_gnt_i && (sel == 1'b1);

    assign vrf_id_o    = vrf_req_o ? head[EntWidth-1 -: IdWidth] : '0;
    assign vrf_addr_o  = vrf_req_o ? head[DataWidth+BeWidth +: AddrWidth] : '0;
    assign vrf_wdata_o = vrf_req_o ? head[BeWidth +: DataWidth] : '0;
    assign vrf_be_o    = vrf_req_o ? head[BeWidth-1:0] : '0;

    // FIFO pointers and occupancy. Power-of-two depth makes pointer overflow wrap modulo Depth.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 2; s++) begin
            if (rst_i) begin
                rptr_q[s] <= '0;
                wptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end else begin
                if (push[s]) wptr_q[s] <= wptr_q[s] + 1'b1;
                if (pop[s])  rptr_q[s] <= rptr_q[s] + 1'b1;
                cnt_q[s] <= cnt_q[s] + CntWidth'(push[s]) - CntWidth'(pop[s]);
            end
        end
    end

    // FIFO storage. There is no reset here because occupancy alone decides validity.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) mem_q[s][wptr_q[s]] <= ent_in[s];
        end
    end

    // Arbiter next state: lock on an ungranted request, and release and record the winner on a grant.
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        last_d     = last_q;
        if (vrf_req_o) begin
            if (vrf_gnt_i) begin
                state_d = IDLE;
                last_d  = sel;
            end else begin
                state_d    = LOCKED;
                lock_src_d = sel;
            end
        end
    end

    // Arbiter state registers. After reset, last winner is MFPU so the ALU wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_src_q <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            last_q     <= last_d;
        end
    end

`ifdef VRF_WB_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count presented-but-ungranted cycles and saturate at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (vrf_req_o && !vrf_gnt_i && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Randomized and directed bench for vrf_wb_arbiter, compared cycle by cycle against a queue-based model.
module tb_vrf_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [2:0]  id;
        logic [9:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_req, mfpu_req, alu_gnt, mfpu_gnt;
    logic [2:0]  alu_id, mfpu_id, vrf_id;
    logic [9:0]  alu_addr, mfpu_addr, vrf_addr;
    logic [63:0] alu_wdata, mfpu_wdata, vrf_wdata;
    logic [7:0]  alu_be, mfpu_be, vrf_be;
    logic        vrf_req, vgnt;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    ent_t qa[$];
    ent_t qm[$];
    int   cur  = -1;
    int   last = 1;
    int   m_stall = 0;

    vrf_wb_arbiter #(.DataWidth(64), .AddrWidth(10), .IdWidth(3), .Depth(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .alu_result_req_i(alu_req), .alu_result_id_i(alu_id), .alu_result_addr_i(alu_addr),
        .alu_result_wdata_i(alu_wdata), .alu_result_be_i(alu_be), .alu_result_gnt_o(alu_gnt),
        .mfpu_result_req_i(mfpu_req), .mfpu_result_id_i(mfpu_id), .mfpu_result_addr_i(mfpu_addr),
        .mfpu_result_wdata_i(mfpu_wdata), .mfpu_result_be_i(mfpu_be), .mfpu_result_gnt_o(mfpu_gnt),
        .vrf_req_o(vrf_req), .vrf_id_o(vrf_id), .vrf_addr_o(vrf_addr), .vrf_wdata_o(vrf_wdata),
        .vrf_be_o(vrf_be), .vrf_gnt_i(vgnt), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Source the model would present now: a held source, the previous loser on a tie, or the only non-empty one.
    function automatic int m_sel();
        if (cur >= 0) return cur;
        if (qa.size() > 0 && qm.size() > 0) return 1 - last;
        if (qa.size() > 0) return 0;
        if (qm.size() > 0) return 1;
        return -1;
    endfunction

    // Compare DUT outputs with the model for the driven inputs, then advance one clock.
    task automatic step();
        ent_t h;
        int   s;
        logic ga, gm;
        #1;
        ga = alu_req && (qa.size() < DEPTH) && !rst;
        gm = mfpu_req && (qm.size() < DEPTH) && !rst;
        s  = rst ? -1 : m_sel();
        h  = '0;
        if (s == 0) h = qa[0];
        else if (s == 1) h = qm[0];
        chk("alu_gnt", alu_gnt, ga);
        chk("mfpu_gnt", mfpu_gnt, gm);
        chk("vrf_req", vrf_req, s >= 0);
        chk("vrf_id", vrf_id, h.id);
        chk("vrf_addr", vrf_addr, h.addr);
        chk("vrf_wdata", vrf_wdata, h.wdata);
        chk("vrf_be", vrf_be, h.be);
        chk("stall_cnt", stall_cnt, m_stall);
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qm.delete();
            cur = -1;
            last = 1;
            m_stall = 0;
        end else begin
`ifdef VRF_WB_STALL_CNT_EN
            if (s >= 0 && !vgnt && m_stall < 65535) m_stall++;
`endif
            if (s >= 0 && vgnt) begin
                if (s == 0) void'(qa.pop_front());
                else void'(qm.pop_front());
                last = s;
                cur = -1;
            end else if (s >= 0) begin
                cur = s;
            end
            if (ga) qa.push_back({alu_id, alu_addr, alu_wdata, alu_be});
            if (gm) qm.push_back({mfpu_id, mfpu_addr, mfpu_wdata, mfpu_be});
        end
        @(negedge clk);
    endtask

    task automatic drv_alu(input logic r, input logic [9:0] a, input logic [63:0] d);
        alu_req = r; alu_addr = a; alu_wdata = d; alu_id = a[2:0]; alu_be = a[7:0] ^ 8'hFF;
    endtask

    task automatic drv_mfpu(input logic r, input logic [9:0] a, input logic [63:0] d);
        mfpu_req = r; mfpu_addr = a; mfpu_wdata = d; mfpu_id = a[4:2]; mfpu_be = a[9:2];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vgnt = 1'b0;
        drv_alu(1'b0, 10'h0, 64'h0);
        drv_mfpu(1'b0, 10'h0, 64'h0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        step();
        rst = 1'b0;

        // Single write with the grant held high.
        vgnt = 1'b1;
        drv_alu(1'b1, 10'h012, 64'hDEADBEEF_00000001);
        alu_be = 8'hFF;
        #1 chk("single_gnt", alu_gnt, 1'b1);
        step();
        drv_alu(1'b0, 10'h0, 64'h0);
        #1 chk("single_req1", vrf_req, 1'b1);
        chk("single_addr", vrf_addr, 10'h012);
        chk("single_wdata", vrf_wdata, 64'hDEADBEEF_00000001);
        chk("single_be", vrf_be, 8'hFF);
        step();
        #1 chk("single_req2", vrf_req, 1'b0);
        step();

        // Ties after reset: the ALU goes first both times.
        do_reset();
        vgnt = 1'b1;
        for (int r = 0; r < 2; r++) begin
            drv_alu(1'b1, 10'h100 + 10'(r), 64'hA);
            drv_mfpu(1'b1, 10'h200 + 10'(r), 64'hB);
            step();
            drv_alu(1'b0, 10'h0, 64'h0);
            drv_mfpu(1'b0, 10'h0, 64'h0);
            #1 chk("tie_first", vrf_addr, 10'h100 + 10'(r));
            step();
            #1 chk("tie_second", vrf_addr, 10'h200 + 10'(r));
            step();
        end

        // Backpressure for five cycles, with a late MFPU arrival that must not preempt.
        do_reset();
        vgnt = 1'b0;
        drv_alu(1'b1, 10'h055, 64'h1234);
        step();
        drv_alu(1'b0, 10'h0, 64'h0);
        for (int c = 0; c < 5; c++) begin
            drv_mfpu(c == 1, 10'h3AA, 64'h9999);
            #1 chk("bp_hold", vrf_addr, 10'h055);
            step();
        end
        drv_mfpu(1'b0, 10'h0, 64'h0);
`ifdef VRF_WB_STALL_CNT_EN
        chk("bp_stall", stall_cnt, 16'd5);
`else
        chk("bp_stall", stall_cnt, 16'd0);
`endif
        vgnt = 1'b1;
        step(); step(); step();

        // A full FIFO refuses a third back-to-back push.
        do_reset();
        vgnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drv_alu(1'b1, 10'h010 + 10'(c), 64'(c));
            #1 chk("full_gnt", alu_gnt, c < 2);
            step();
        end
        drv_alu(1'b0, 10'h0, 64'h0);
        vgnt = 1'b1;
        for (int c = 0; c < 4; c++) step();

        // Reset while locked with both FIFOs full.
        do_reset();
        vgnt = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drv_alu(1'b1, 10'h020 + 10'(c), 64'h5);
            drv_mfpu(1'b1, 10'h030 + 10'(c), 64'h6);
            step();
        end
        rst = 1'b1;
        #1 chk("rst_alu_gnt", alu_gnt, 1'b0);
        chk("rst_mfpu_gnt", mfpu_gnt, 1'b0);
        step();
        rst = 1'b0;
        drv_alu(1'b0, 10'h0, 64'h0);
        drv_mfpu(1'b0, 10'h0, 64'h0);
        #1 chk("rst_req", vrf_req, 1'b0);
        chk("rst_stall", stall_cnt, 16'd0);
        step();
        vgnt = 1'b1;
        step();

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            vgnt = ($urandom_range(0, 3) != 0);
            drv_alu($urandom_range(0, 1), 10'($urandom), {$urandom, $urandom});
            drv_mfpu($urandom_range(0, 1), 10'($urandom), {$urandom, $urandom});
            alu_be = 8'($urandom);
            step();
        end
        rst = 1'b0;

        // Long stall to exercise counter saturation.
        do_reset();
        vgnt = 1'b0;
        drv_alu(1'b1, 10'h3FF, 64'h77);
        drv_mfpu(1'b0, 10'h0, 64'h0);
        step();
        drv_alu(1'b0, 10'h0, 64'h0);
        for (int c = 0; c < 70000; c++) step();
`ifdef VRF_WB_STALL_CNT_EN
        chk("sat_stall", stall_cnt, 16'hFFFF);
`else
        chk("sat_stall", stall_cnt, 16'h0000);
`endif
        vgnt = 1'b1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
